// File: rtl/fdct_pkg.sv
// Shared widths, state encoding and the cosine-constant ROM for the 8x8 forward DCT.
package fdct_pkg;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 16;
  localparam int CST_W  = 14;
  localparam int FRAC   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2
  } state_t;

  // 2048*cos(k*pi/16) for the first quadrant, k = 0..8
  function automatic logic signed [CST_W-1:0] cos_mag(input logic [4:0] k);
    case (k)
      5'd0:    return 14'sd2048;
      5'd1:    return 14'sd2009;
      5'd2:    return 14'sd1892;
      5'd3:    return 14'sd1703;
      5'd4:    return 14'sd1448;
      5'd5:    return 14'sd1138;
      5'd6:    return 14'sd784;
      5'd7:    return 14'sd400;
      default: return 14'sd0;
    endcase
  endfunction

  // A[u][x]: DC row uses 4096/sqrt(8); other rows fold (2x+1)*u mod 32 onto the first quadrant
  function automatic logic signed [CST_W-1:0] cos_c(input logic [2:0] u, input logic [2:0] x);
    logic [4:0] k;
    k = {1'b0, x, 1'b1} * {2'b00, u};
    if (u == 3'd0)       return 14'sd1448;
    else if (k <= 5'd8)  return cos_mag(k);
    else if (k <= 5'd16) return -cos_mag(5'd16 - k);
    else if (k <= 5'd24) return -cos_mag(k - 5'd16);
    else                 return cos_mag(5'd0 - k);
  endfunction

endpackage

// File: rtl/fdct_mac8.sv
// Eight-lane multiply/accumulate: dot product of data and cosine lanes, rounded and clamped to 16b.
module fdct_mac8
  import fdct_pkg::*;
(
  input  logic [8*COEF_W-1:0] i_data,
  input  logic [8*CST_W-1:0]  i_cst,
  output logic [COEF_W-1:0]   o_res
);

  logic signed [COEF_W-1:0] w_d    [8];
  logic signed [CST_W-1:0]  w_c    [8];
  logic signed [31:0]       w_prod [8];
  logic signed [31:0]       w_s1   [4];
  logic signed [31:0]       w_s2   [2];
  logic signed [31:0]       w_sum;

  // round half up: add half an LSB of the fractional part, then arithmetic shift
  function automatic logic signed [31:0] rnd(input logic signed [31:0] s);
    return (s + (32'sd1 <<< (FRAC - 1))) >>> FRAC;
  endfunction

  // clamp to the signed 16b coefficient range
  function automatic logic [COEF_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7fff;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[COEF_W-1:0];
  endfunction

  // full-precision products feeding a three-level adder tree
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_d[i]    = i_data[i*COEF_W +: COEF_W];
      w_c[i]    = i_cst[i*CST_W +: CST_W];
      w_prod[i] = 32'(w_d[i]) * 32'(w_c[i]);
    end
    for (int i = 0; i < 4; i++) w_s1[i] = w_prod[2*i] + w_prod[2*i+1];
    for (int i = 0; i < 2; i++) w_s2[i] = w_s1[2*i] + w_s1[2*i+1];
    w_sum = w_s2[0] + w_s2[1];
  end

  assign o_res = sat16(rnd(w_sum));

endmodule

// File: rtl/fdct_8x8.sv
// Forward 8x8 2-D DCT: row pass into R buffer, column pass into the coefficient register,
// one MAC result per cycle through a shared eight-lane MAC.
module fdct_8x8
  import fdct_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [64*PIX_W-1:0]   pix_flat,
  output logic [64*COEF_W-1:0]  coef_flat,
  output logic                  busy,
  output logic                  done
);

  state_t                   r_state;
  logic [5:0]               r_cnt;
  logic signed [PIX_W:0]    r_x [64];
  logic signed [COEF_W-1:0] r_r [64];
  logic [64*COEF_W-1:0]     r_coef;
  logic                     r_busy;
  logic                     r_done;

  logic [2:0]               w_hi;
  logic [2:0]               w_lo;
  logic [8*COEF_W-1:0]      w_data;
  logic [8*CST_W-1:0]       w_cst;
  logic [COEF_W-1:0]        w_res;

  assign w_hi      = r_cnt[5:3];
  assign w_lo      = r_cnt[2:0];
  assign coef_flat = r_coef;
  assign busy      = r_busy;
  assign done      = r_done;

  // lane mux: ROW feeds X[y][x] with A[u][x]; COL feeds R[y][u] with A[v][y]
  always_comb begin
    w_data = '0;
    w_cst  = '0;
    for (int i = 0; i < 8; i++) begin
      if (r_state == COL) begin
        w_data[i*COEF_W +: COEF_W] = r_r[{3'(i), w_lo}];
        w_cst[i*CST_W +: CST_W]    = cos_c(w_hi, 3'(i));
      end else begin
        w_data[i*COEF_W +: COEF_W] = 16'(r_x[{w_hi, 3'(i)}]);
        w_cst[i*CST_W +: CST_W]    = cos_c(w_lo, 3'(i));
      end
    end
  end

  fdct_mac8 u_mac (
    .i_data (w_data),
    .i_cst  (w_cst),
    .o_res  (w_res)
  );

  // control FSM plus X/R buffers and coefficient register; rst aborts any job
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_coef  <= '0;
      for (int i = 0; i < 64; i++) begin
        r_x[i] <= '0;
        r_r[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 64; i++)
              r_x[i] <= $signed({1'b0, pix_flat[i*PIX_W +: PIX_W]}) - 9'sd128;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ROW;
          end
        end
        ROW: begin
          r_r[r_cnt] <= w_res;
          r_cnt      <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_cnt   <= '0;
            r_state <= COL;
          end
        end
        COL: begin
          r_coef[{r_cnt, 4'b0000} +: COEF_W] <= w_res;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdct_8x8.sv
// Self-checking bench for fdct_8x8: reference model results queued at start, compared at done.
module tb_fdct_8x8;

  localparam real PI = 3.14159265358979;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [511:0]  pix;
  logic [1023:0] coef;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_err  = 0;
  int edge_n = 0;
  int n_done = 0;
  int A [8][8];

  typedef struct {
    logic [1023:0] v;
    int            st;
  } sb_t;
  sb_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  fdct_8x8 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_flat  (pix),
    .coef_flat (coef),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rndc(input longint s);
    longint t;
    t = (s + 64'sd2048) >>> 12;
    return int'(t);
  endfunction

  function automatic int cget(input logic [1023:0] c, input int i);
    logic signed [15:0] t;
    t = c[i*16 +: 16];
    return int'(t);
  endfunction

  function automatic logic [1023:0] model(input logic [511:0] p);
    int X [64];
    int R [64];
    int f;
    longint s;
    logic [1023:0] out;
    out = '0;
    for (int i = 0; i < 64; i++) X[i] = int'(p[i*8 +: 8]) - 128;
    for (int y = 0; y < 8; y++)
      for (int u = 0; u < 8; u++) begin
        s = 0;
        for (int x = 0; x < 8; x++) s += longint'(X[y*8+x]) * A[u][x];
        R[y*8+u] = rndc(s);
      end
    for (int v = 0; v < 8; v++)
      for (int u = 0; u < 8; u++) begin
        s = 0;
        for (int y = 0; y < 8; y++) s += longint'(A[v][y]) * R[y*8+u];
        f = rndc(s);
        if (f > 32767) f = 32767;
        if (f < -32768) f = -32768;
        out[(v*8+u)*16 +: 16] = 16'(f);
      end
    return out;
  endfunction

  task automatic start_job(input logic [511:0] p, input bit push);
    sb_t e;
    pix   = p;
    start = 1'b1;
    if (push) begin
      e.v  = model(p);
      e.st = edge_n + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int k = 0;
    while (!done && k < max) begin
      @(negedge clk);
      k++;
    end
    check(tag, done, 1);
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[i*8 +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  // scoreboard: every done pops one expected block and checks latency and all 64 coefficients
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("latency", edge_n - e.st, 128);
          for (int i = 0; i < 64; i++)
            check($sformatf("coef%0d", i), cget(coef, i), cget(e.v, i));
        end
      end
    end
  end

  initial begin
    logic [511:0] p;
    logic [511:0] pr;
    int st, bl, k, d0, d1;
    real c, s, err, maxerr, cu, cv;

    for (int u = 0; u < 8; u++)
      for (int x = 0; x < 8; x++) begin
        c = (u == 0) ? 4096.0 / $sqrt(8.0) : 2048.0 * $cos((2*x+1) * u * PI / 16.0);
        A[u][x] = (c >= 0.0) ? $rtoi(c + 0.5) : -$rtoi(-c + 0.5);
      end

    rst = 1'b1; start = 1'b0; pix = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_coef_any", |coef, 0);
    rst = 1'b0;
    @(negedge clk);

    // all 128: zero block, busy high until done
    start_job({64{8'd128}}, 1'b1);
    bl = 0; k = 0;
    while (!done && k < 300) begin
      if (!busy) bl++;
      @(negedge clk);
      k++;
    end
    check("t1_timeout", done, 1);
    check("t1_busy_low_cycles", bl, 0);
    check("t1_c0", cget(coef, 0), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    start_job({64{8'd255}}, 1'b1);
    wait_done(300, "t2_timeout");
    check("t2_c0", cget(coef, 0), 1015);
    check("t2_c9", cget(coef, 9), 0);
    @(negedge clk);

    start_job({64{8'd0}}, 1'b1);
    wait_done(300, "t3_timeout");
    check("t3_c0", cget(coef, 0), -1024);
    check("t3_c63", cget(coef, 63), 0);
    @(negedge clk);

    p = {64{8'd128}};
    p[7:0] = 8'd255;
    start_job(p, 1'b1);
    wait_done(300, "t4_timeout");
    check("t4_c0", cget(coef, 0), 16);
    @(negedge clk);

    // start re-pulses during a job are ignored; pixels changing mid-job are not re-captured
    d0 = n_done;
    st = edge_n + 1;
    start_job(rand_blk(), 1'b1);
    pix = rand_blk();
    k = 0;
    while (!done && k < 300) begin
      start = (edge_n == st + 4 || edge_n == st + 69);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("t5_timeout", done, 1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) pr[(y*8+x)*8 +: 8] = 8'(16*x + 8*y);
    start_job(pr, 1'b1);
    wait_done(300, "t5b_timeout");

    // round trip through an ideal inverse DCT
    maxerr = 0.0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        s = 0.0;
        for (int v = 0; v < 8; v++)
          for (int u = 0; u < 8; u++) begin
            cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            s += cu * cv * cget(coef, v*8+u) * $cos((2*x+1) * u * PI / 16.0)
                 * $cos((2*y+1) * v * PI / 16.0);
          end
        err = s / 4.0 + 128.0 - real'(16*x + 8*y);
        if (err < 0.0) err = -err;
        if (err > maxerr) maxerr = err;
      end
    check("roundtrip_within_2", (maxerr <= 2.0) ? 1 : 0, 1);
    @(negedge clk);
    check("t5_dones", n_done - d0, 2);

    // reset during COL at cnt=20 aborts with no done
    st = edge_n + 1;
    start_job(rand_blk(), 1'b0);
    k = 0;
    while (edge_n < st + 84 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6_pre_coef_nz", |coef, 1);
    check("t6_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_coef_any", |coef, 0);
    rst = 1'b0;
    d1 = n_done;
    repeat (200) @(negedge clk);
    check("t6_no_done", n_done - d1, 0);
    check("t6_busy_idle", busy, 0);

    start_job(rand_blk(), 1'b1);
    wait_done(300, "t6b_timeout");
    @(negedge clk);

    check("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
